count_mod: RTL and testbench

Parametrised modulo up/down counter for the count example family, generalising the fixed 8-bit free-running counter. Adds:
- configurable width, modulus and prescaler
- wrap or saturate mode
- enable, direction, synchronous clear, parallel load
- a terminal-count pulse and a sticky overflow flag

Used as a timebase or event counter inside example DUTs.

---
 rtl/count_mod.sv | 129 ++++++++++++
 tb/tb_count_mod.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_mod.sv
`default_nettype none
// ============================================================================
//  Module   : count_mod
//  Purpose  : Parametrised modulo up/down counter with prescaler, wrap or
//             saturate behaviour at the limits, synchronous clear, parallel
//             load, a one-cycle terminal-count pulse and a sticky overflow
//             flag. Intended as a timebase or event counter.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      counter width in bits (1..32)
//    MAX        highest count value, MAX < 2**WIDTH
//    PRESCALE   enabled cycles per count step (>= 1)
//    SATURATE   0 = wrap at the limits, 1 = hold at the limits
//  Ports
//    clk         in   clock, rising edge
//    rst         in   asynchronous active-high reset
//    en          in   advances the prescaler; steps only happen when high
//    up          in   1 = count up, 0 = count down (used on step edges)
//    clear       in   synchronous clear of count, prescaler, tc and ovf
//    load        in   synchronous load of min(load_value, MAX)
//    load_value  in   value to load
//    count       out  current count (registered)
//    tc          out  terminal-count pulse, coincident with the new count
//    ovf         out  sticky flag, set with any tc
// ============================================================================
module count_mod #(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX      = 255,
    parameter int          PRESCALE = 1,
    parameter int          SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // A prescaler of 1 still needs a register bit to keep the logic uniform;
    // it simply never leaves zero.
    localparam int              PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] C_MAX_VAL  = WIDTH'(MAX);
    localparam logic [PW-1:0]    C_PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [PW-1:0]    pre_q;
    logic [PW-1:0]    pre_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;

    // Boundary value after a limit step: hold when saturating, otherwise
    // wrap to the opposite limit.
    logic [WIDTH-1:0] w_up_limit;
    logic [WIDTH-1:0] w_dn_limit;

    assign w_up_limit = (SATURATE != 0) ? C_MAX_VAL : '0;
    assign w_dn_limit = (SATURATE != 0) ? '0 : C_MAX_VAL;

    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;

        if (clear) begin
            count_d = '0;
            pre_d   = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            // Clamp so the count can never be loaded above MAX.
            count_d = (load_value > C_MAX_VAL) ? C_MAX_VAL : load_value;
            pre_d   = '0;
        end else if (en) begin
            if (pre_q == C_PRE_LAST) begin
                pre_d = '0;
                if (up) begin
                    // >= guards against an out-of-range count ever wrapping
                    // through the full binary range.
                    if (count_q >= C_MAX_VAL) begin
                        count_d = w_up_limit;
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = w_dn_limit;
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_count_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_mod
//  Purpose  : Self-checking bench for count_mod. Three instances share one
//             stimulus stream:
//               0: WIDTH=4 MAX=9   PRESCALE=1 SATURATE=0
//               1: WIDTH=4 MAX=9   PRESCALE=1 SATURATE=1
//               2: WIDTH=8 MAX=255 PRESCALE=3 SATURATE=0
//             Each instance is tracked by an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_count_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] lv = 8'd0;

    logic [3:0] cnt0;
    logic [3:0] cnt1;
    logic [7:0] cnt2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;

    always #5 clk = ~clk;

    count_mod #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_value(lv[3:0]), .count(cnt0), .tc(tc0), .ovf(ovf0));

    count_mod #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_value(lv[3:0]), .count(cnt1), .tc(tc1), .ovf(ovf1));

    count_mod #(.WIDTH(8), .MAX(255), .PRESCALE(3), .SATURATE(0)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear), .load(load),
        .load_value(lv), .count(cnt2), .tc(tc2), .ovf(ovf2));

    // ---------------- reference model ----------------
    int p_w[3]   = '{4, 4, 8};
    int p_max[3] = '{9, 9, 255};
    int p_pre[3] = '{1, 1, 3};
    int p_sat[3] = '{0, 1, 0};

    int m_cnt[3];
    int m_pre[3];
    int m_tc[3];
    int m_ovf[3];

    int n_checks = 0;
    int n_err    = 0;

    function automatic void mreset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
        end
    endfunction

    function automatic void mstep(int k);
        int v;
        m_tc[k] = 0;
        if (clear) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_ovf[k] = 0;
        end else if (load) begin
            v = int'(lv) % (1 << p_w[k]);
            m_cnt[k] = (v > p_max[k]) ? p_max[k] : v;
            m_pre[k] = 0;
        end else if (en) begin
            m_pre[k] = m_pre[k] + 1;
            if (m_pre[k] == p_pre[k]) begin
                m_pre[k] = 0;
                if (up) begin
                    if (m_cnt[k] < p_max[k]) m_cnt[k] = m_cnt[k] + 1;
                    else begin
                        m_cnt[k] = p_sat[k] ? p_max[k] : 0;
                        m_tc[k] = 1; m_ovf[k] = 1;
                    end
                end else begin
                    if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                    else begin
                        m_cnt[k] = p_sat[k] ? 0 : p_max[k];
                        m_tc[k] = 1; m_ovf[k] = 1;
                    end
                end
            end
        end
    endfunction

    function automatic int act_cnt(int k);
        case (k)
            0: return int'(cnt0);
            1: return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int act_tc(int k);
        case (k)
            0: return int'(tc0);
            1: return int'(tc1);
            default: return int'(tc2);
        endcase
    endfunction

    function automatic int act_ovf(int k);
        case (k)
            0: return int'(ovf0);
            1: return int'(ovf1);
            default: return int'(ovf2);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s dut%0d count", tag, k), act_cnt(k), m_cnt[k]);
            chk($sformatf("%s dut%0d tc", tag, k), act_tc(k), m_tc[k]);
            chk($sformatf("%s dut%0d ovf", tag, k), act_ovf(k), m_ovf[k]);
        end
    endtask

    task automatic drive(input bit e, input bit u, input bit c, input bit l, input int v);
        en = e; up = u; clear = c; load = l; lv = 8'(v);
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every instance 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst) mreset();
        else for (int k = 0; k < 3; k++) mstep(k);
        #1;
        compare_all(tag);
    endtask

    // ---------------- directed table for instance 0 ----------------
    typedef struct {
        bit en; bit up; bit clr; bit ld; int lv;
        int e_cnt; int e_tc; int e_ovf;
    } vec_t;

    vec_t tbl[17];

    initial begin
        // 12 up steps from reset: 1..9, wrap to 0 with tc, then 1, 2
        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{1, 1, 0, 0, 0, (i + 1) % 10, (i == 9) ? 1 : 0, (i >= 9) ? 1 : 0};
        end
        tbl[12] = '{1, 0, 1, 0, 0, 0, 0, 0};   // clear to restart from 0
        tbl[13] = '{1, 0, 0, 0, 0, 9, 1, 1};   // down from 0 wraps to MAX
        tbl[14] = '{1, 0, 0, 0, 0, 8, 0, 1};
        tbl[15] = '{1, 0, 0, 0, 0, 7, 0, 1};
        tbl[16] = '{0, 0, 1, 0, 0, 0, 0, 0};   // clear drops ovf
    end

    // ---------------- test sequence ----------------
    initial begin
        mreset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all("reset");

        // Directed table on the wrapping decimal counter
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].ld, tbl[i].lv);
            cycle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d count", i), int'(cnt0), tbl[i].e_cnt);
            chk($sformatf("tbl%0d tc", i), int'(tc0), tbl[i].e_tc);
            chk($sformatf("tbl%0d ovf", i), int'(ovf0), tbl[i].e_ovf);
        end

        // Saturation on instance 1: load 8, four up steps, one down step
        drive(0, 0, 1, 0, 0); cycle("sat clr");
        drive(0, 0, 0, 1, 8); cycle("sat load");
        chk("sat load count", int'(cnt1), 8);
        drive(1, 1, 0, 0, 0); cycle("sat up1");
        chk("sat up1 count", int'(cnt1), 9);
        chk("sat up1 tc", int'(tc1), 0);
        for (int i = 0; i < 3; i++) begin
            cycle("sat hold");
            chk("sat hold count", int'(cnt1), 9);
            chk("sat hold tc", int'(tc1), 1);
            chk("sat hold ovf", int'(ovf1), 1);
        end
        drive(1, 0, 0, 0, 0); cycle("sat down");
        chk("sat down count", int'(cnt1), 8);
        chk("sat down tc", int'(tc1), 0);

        // Prescaler on instance 2
        drive(0, 0, 1, 0, 0); cycle("pre clr");
        begin
            int exp_pre[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
            drive(1, 1, 0, 0, 0);
            for (int i = 0; i < 9; i++) begin
                cycle("pre run");
                chk($sformatf("pre run%0d count", i), int'(cnt2), exp_pre[i]);
            end
        end
        cycle("pre phase1");                           // phase 1 of 3
        drive(0, 1, 0, 0, 0); cycle("pre hold1");
        drive(0, 1, 0, 0, 0); cycle("pre hold2");
        chk("pre hold count", int'(cnt2), 3);
        drive(1, 1, 0, 0, 0); cycle("pre resume1");
        chk("pre resume1 count", int'(cnt2), 3);
        cycle("pre resume2");
        chk("pre resume2 count", int'(cnt2), 4);

        // Load clamp and priority on instance 0
        drive(0, 0, 0, 1, 15); cycle("ld clamp");
        chk("ld clamp count", int'(cnt0), 9);
        drive(1, 1, 1, 1, 5); cycle("clr over ld");
        chk("clr over ld count", int'(cnt0), 0);
        drive(0, 0, 0, 1, 9); cycle("ld nine");
        drive(1, 1, 0, 1, 3); cycle("ld over step");
        chk("ld over step count", int'(cnt0), 3);
        chk("ld over step tc", int'(tc0), 0);

        // Asynchronous reset mid-count
        drive(0, 0, 1, 0, 0); cycle("ar clr");
        drive(0, 0, 0, 1, 9); cycle("ar load");
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle("ar count");
        drive(0, 1, 0, 0, 0);
        chk("ar pre count", int'(cnt0), 5);
        chk("ar pre ovf", int'(ovf0), 1);
        #3;
        rst = 1'b1;
        #1;
        mreset();
        chk("ar async count", int'(cnt0), 0);
        chk("ar async ovf", int'(ovf0), 0);
        compare_all("ar async");
        cycle("ar held");
        rst = 1'b0;
        drive(1, 1, 0, 0, 0); cycle("ar restart");
        chk("ar restart count", int'(cnt0), 1);

        // Randomised run against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 11) == 0), int'($urandom_range(0, 255)));
            cycle($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
